// File: rtl/max_score_tracker_pkg.sv
// Shared types and constants for the score tracker: cell/tile types, state encoding,
// and helpers that size coordinate and counter fields.
package sw_pkg;

    localparam int SCORE_WIDTH   = 8;
    localparam int NUM_ROWS_COLS = 1;
    localparam int TILE_DIM      = NUM_ROWS_COLS + 1;
    localparam int RC_WIDTH      = (TILE_DIM > 1) ? $clog2(TILE_DIM) : 1;

    typedef logic [SCORE_WIDTH-1:0] score_t;
    typedef score_t [NUM_ROWS_COLS:0][NUM_ROWS_COLS:0] tile_t;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} tracker_state_e;

    // Never returns 0 so single-tile configurations still get a 1-bit field.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int coord_width(input int tiles_per_row, input int tiles_per_col);
        return clog2_min1(((tiles_per_row > tiles_per_col) ? tiles_per_row : tiles_per_col) * TILE_DIM);
    endfunction

    localparam int COORD_WIDTH_DEFAULT = coord_width(16, 16);
    typedef logic [COORD_WIDTH_DEFAULT-1:0] coord_t;

endpackage

// File: rtl/max_score_tracker_if.sv
// Tile input and result bundle between the processing unit side and the tracker.
interface max_score_tracker_if
    import sw_pkg::*;
#(
    parameter int COORD_WIDTH = COORD_WIDTH_DEFAULT
);
    logic                   start;
    logic                   pu_valid;
    tile_t                  scores_in;
    logic                   busy;
    logic                   done;
    score_t                 max_score;
    logic [COORD_WIDTH-1:0] max_row;
    logic [COORD_WIDTH-1:0] max_col;

    modport master (
        output start, pu_valid, scores_in,
        input  busy, done, max_score, max_row, max_col
    );

    modport slave (
        input  start, pu_valid, scores_in,
        output busy, done, max_score, max_row, max_col
    );
endinterface

// File: rtl/max_score_tracker_tile_max_reduce.sv
// Combinational reduction of one tile to its maximum and the local (r,c) of that maximum.
module tile_max_reduce
    import sw_pkg::*;
(
    input  tile_t               tile,
    output score_t              tile_max,
    output logic [RC_WIDTH-1:0] max_r,
    output logic [RC_WIDTH-1:0] max_c
);

    // Row-major scan with strict '>' so the earliest cell keeps a tie.
    always_comb begin
        tile_max = tile[0][0];
        max_r    = '0;
        max_c    = '0;
        for (int r = 0; r <= NUM_ROWS_COLS; r++) begin
            for (int c = 0; c <= NUM_ROWS_COLS; c++) begin
                if (tile[r][c] > tile_max) begin
                    tile_max = tile[r][c];
                    max_r    = RC_WIDTH'(r);
                    max_c    = RC_WIDTH'(c);
                end
            end
        end
    end

endmodule

// File: rtl/max_score_tracker.sv
// Running maximum score and its matrix position over one raster pass of PU tiles.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | accepting tiles on pu_valid
//   FLUSH | last tile accepted, draining the two pipe stages
//   DONE  | result final on max_*, waiting for next start
module max_score_tracker
    import sw_pkg::*;
#(
    parameter int TILES_PER_ROW = 16,
    parameter int TILES_PER_COL = 16,
    parameter int COORD_WIDTH   = coord_width(TILES_PER_ROW, TILES_PER_COL)
)
(
    input logic                 clk,
    input logic                 rst,
    max_score_tracker_if.slave  bus
);

    localparam int COL_W = clog2_min1(TILES_PER_ROW);
    localparam int ROW_W = clog2_min1(TILES_PER_COL);

    tracker_state_e         state;
    logic [COL_W-1:0]       tile_col;
    logic [ROW_W-1:0]       tile_row;

    logic                   s1_valid;
    logic                   s2_valid;
    score_t                 s1_score;
    logic [COORD_WIDTH-1:0] s1_row;
    logic [COORD_WIDTH-1:0] s1_col;

    score_t                 red_max;
    logic [RC_WIDTH-1:0]    red_r;
    logic [RC_WIDTH-1:0]    red_c;

    logic                   accept;
    logic                   col_wrap;
    logic                   last_tile;
    logic                   pipe_empty;

    assign accept     = (state == RUN) && bus.pu_valid;
    assign col_wrap   = (tile_col == COL_W'(TILES_PER_ROW - 1));
    assign last_tile  = col_wrap && (tile_row == ROW_W'(TILES_PER_COL - 1));
    assign pipe_empty = !s1_valid && !s2_valid;

    tile_max_reduce u_reduce (
        .tile     (bus.scores_in),
        .tile_max (red_max),
        .max_r    (red_r),
        .max_c    (red_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            tile_col <= '0;
            tile_row <= '0;
        end else if (bus.start) begin
            state    <= RUN;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
            tile_col <= '0;
            tile_row <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        if (last_tile) begin
                            tile_col <= '0;
                            tile_row <= '0;
                            state    <= FLUSH;
                        end else if (col_wrap) begin
                            tile_col <= '0;
                            tile_row <= tile_row + 1'b1;
                        end else begin
                            tile_col <= tile_col + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (pipe_empty) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage 1 holds the tile winner in matrix coordinates; stage 2 folds it into the running max.
    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            s1_score      <= '0;
            s1_row        <= '0;
            s1_col        <= '0;
            bus.max_score <= '0;
            bus.max_row   <= '0;
            bus.max_col   <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (accept) begin
                s1_score <= red_max;
                s1_row   <= COORD_WIDTH'(int'(tile_row) * TILE_DIM + int'(red_r));
                s1_col   <= COORD_WIDTH'(int'(tile_col) * TILE_DIM + int'(red_c));
            end
            if (s1_valid && (s1_score > bus.max_score)) begin
                bus.max_score <= s1_score;
                bus.max_row   <= s1_row;
                bus.max_col   <= s1_col;
            end
        end
    end

endmodule
